// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioning stage.
package btn_pkg;

  localparam int unsigned NUM_BTN_DEFAULT = 4;

  typedef enum logic [1:0] {
    StLow,
    StPendHigh,
    StHigh,
    StPendLow
  } ch_state_e;

  // Callers zero-extend narrower vectors; NUM_BTN is expected to stay <= 32.
  function automatic bit is_onehot(input logic [31:0] vec);
    return $countones(vec) == 1;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button-side bundle: raw pins in, conditioned levels/pulses and the shared tick out.
interface btn_conditioner_if #(
  parameter int unsigned NUM_BTN = btn_pkg::NUM_BTN_DEFAULT
);
  logic [NUM_BTN-1:0] btn_raw;
  logic               tick;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_onehot;
  logic               multi;

  modport master (
    output btn_raw,
    input  tick, btn_level, btn_rise, btn_onehot, multi
  );

  modport slave (
    input  btn_raw,
    output tick, btn_level, btn_rise, btn_onehot, multi
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-driven debounce FSM, level and rise pulse.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);
  localparam logic [CntW-1:0] StableCnt = CntW'(STABLE_TICKS);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [1:0]      sync_q;
  logic            s;
  ch_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            level_d, level_q, rise_q;

  assign s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (tick) begin
      unique case (state_q)
        StLow: begin
          if (s) begin
            if (STABLE_TICKS == 1) begin
              state_d = StHigh;
            end else begin
              state_d = StPendHigh;
              cnt_d   = CntOne;
            end
          end
        end
        StPendHigh: begin
          if (!s) begin
            state_d = StLow;
            cnt_d   = '0;
          end else if (cnt_inc == StableCnt) begin
            state_d = StHigh;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHigh: begin
          if (!s) begin
            if (STABLE_TICKS == 1) begin
              state_d = StLow;
            end else begin
              state_d = StPendLow;
              cnt_d   = CntOne;
            end
          end
        end
        StPendLow: begin
          if (s) begin
            state_d = StHigh;
            cnt_d   = '0;
          end else if (cnt_inc == StableCnt) begin
            state_d = StLow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StLow;
          cnt_d   = '0;
        end
      endcase
    end
    level_d = (state_d == StHigh) || (state_d == StPendLow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= StLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      // Pulses alongside the first cycle of the new level, so it can never repeat.
      rise_q  <= level_d & ~level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner top: sample-tick prescaler, per-channel debouncers, one-hot/multi qualify.
// Define DBNC_FAST_SIM_EN to force prescale 1 and stable count 2 for short simulations.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN      = NUM_BTN_DEFAULT,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned STABLE_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  btn_conditioner_if.slave bus
);

`ifdef DBNC_FAST_SIM_EN
  localparam int unsigned PrescaleEff = 1;
  localparam int unsigned StableEff   = 2;
`else
  localparam int unsigned PrescaleEff = PRESCALE;
  localparam int unsigned StableEff   = STABLE_TICKS;
`endif

  localparam int unsigned PsW = (PrescaleEff > 1) ? $clog2(PrescaleEff) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PrescaleEff - 1);

  logic [PsW-1:0]     ps_q, ps_d;
  logic               tick_q;
  logic [NUM_BTN-1:0] level, rise;

  always_comb begin
    ps_d = ps_q + 1'b1;
    if (ps_q == PsLast) begin
      ps_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= (ps_q == PsLast);
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(StableEff)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.btn_raw[i]),
      .tick (tick_q),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  assign bus.tick       = tick_q;
  assign bus.btn_level  = level;
  assign bus.btn_rise   = rise;
  assign bus.btn_onehot = is_onehot(32'(level)) ? level : '0;
  assign bus.multi      = ($countones(level) > 1);

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Input-conditioning stage directly upstream of the guessing-game FSM. It synchronises the raw push-button inputs, debounces each channel against a slow sample tick, and produces clean levels, single-cycle press pulses and a one-hot-qualified button vector. It also emits the game step enable `en`, so that the FSM and the conditioner share one timebase.

Parameters:
- NUM_BTN, 4, number of button channels.
- PRESCALE, 100000, clk cycles per sample tick (1 ms at 100 MHz). Must be >= 1.
- STABLE_TICKS, 20, consecutive differing samples required to accept a new level. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- btn_raw  in  NUM_BTN  raw asynchronous button pins, active-high.
- tick  out  1  one-clk pulse every PRESCALE cycles; drives the FSM `en`.
- btn_level  out  NUM_BTN  debounced registered level per channel.
- btn_rise  out  NUM_BTN  one-clk pulse per channel on an accepted 0->1 transition.
- btn_onehot  out  NUM_BTN  equals btn_level when exactly one bit is set, else 0; feeds the FSM `b`.
- multi  out  1  high while more than one btn_level bit is set.

Behaviour:
- Reset: all synchroniser flops, the prescaler, the channel counters and all outputs are 0. Every channel FSM goes to LOW.
- Clock and reset: clk is the clock; rst is asynchronous, active-high, and may assert at any cycle. It immediately clears everything above, including in-flight debounce counts and pending pulses.
- Synchroniser: two flops per channel. sync[i] lags btn_raw[i] by 2 clk.
- Prescaler:
  - Counter runs 0..PRESCALE-1. tick=1 (registered) in the cycle after the counter reads PRESCALE-1, then the counter wraps to 0.
  - PRESCALE=1 gives tick=1 in every cycle after reset release.
- Per-channel FSM (states LOW, PEND_HIGH, HIGH, PEND_LOW). Counter width is clog2(STABLE_TICKS+1). All updates happen only on tick:
  - LOW: sync=1 -> PEND_HIGH, cnt=1. If STABLE_TICKS=1, go straight to HIGH instead.
  - PEND_HIGH: sync=1 -> cnt+1; when cnt+1 == STABLE_TICKS -> HIGH, cnt=0. sync=0 -> LOW, cnt=0 (bounce rejected).
  - HIGH and PEND_LOW mirror LOW and PEND_HIGH with the polarity inverted.
  - btn_level[i] = 1 in HIGH and PEND_LOW.
  - Without tick, state and cnt hold.
- btn_rise[i]:
  - Asserted for exactly the first clk in which btn_level[i]=1.
  - Registered; never asserted in two consecutive cycles.
  - No pulse on a 1->0 transition.
- Latency (PRESCALE=1): a clean step on btn_raw sampled at edge k raises btn_level at edge k+1+STABLE_TICKS.
- Simultaneous presses:
  - Channels are independent; several btn_rise bits may pulse in the same cycle.
  - multi = popcount(btn_level) > 1.
  - btn_onehot is combinational from the registered btn_level.
- Reset released while a button is held: a full STABLE_TICKS qualification is required before btn_level asserts, and btn_rise then pulses once.
- Counters saturate by construction. The prescaler wraps cleanly, and no counter exceeds STABLE_TICKS.

Optional Feature:
- Macro: DBNC_FAST_SIM_EN.
- When defined: the effective prescale is forced to 1 and the effective stable count to 2, regardless of parameters. This gives short simulation runs of the full game.
- When undefined: PRESCALE and STABLE_TICKS are used as given.
- Port list is identical in both builds.

Decomposition:
- Package btn_pkg holds:
  - typedef enum for the channel states LOW/PEND_HIGH/HIGH/PEND_LOW (2-bit).
  - localparam NUM_BTN_DEFAULT = 4.
  - function is_onehot(vector) -> bit.
- Sub-module btn_debounce_ch: synchroniser, FSM, counter, level and rise for one channel, with a tick input. It is instantiated NUM_BTN times in a generate loop.
- Top level contains the prescaler, multi and btn_onehot.

Test Plan:
All scenarios use PRESCALE=1 and STABLE_TICKS=4 unless noted.
- Clean press: btn_raw=4'b0001 from edge 10 -> btn_level=0001 after edge 15; btn_rise=0001 for one cycle only; btn_onehot=0001; multi=0.
- Bounce: btn_raw[1] toggles 1,1,0,1,1,0 on successive edges -> btn_level[1] never asserts; btn_rise stays 0.
- Two buttons: btn_raw=0101 held -> btn_level=0101, btn_rise=0101 in the same cycle, multi=1, btn_onehot=0000.
- Release: hold 0100 until accepted, then btn_raw=0000 -> btn_level falls 5 edges later; no btn_rise on the fall.
- Prescaler: PRESCALE=5 -> tick high in 1 of every 5 cycles; a press needs 4 ticks, so btn_level rises 18-22 clk after the press, depending on phase.
- Reset mid-qualification: assert rst while a channel is in PEND_HIGH with cnt=2 -> all outputs 0 immediately. After release with the button still held, btn_level rises 5 edges later.
